// File: rtl/cva6_feeder_pkg.sv
// Shared types and opcode helpers for the instruction feeder that drives cva6_processor_shim.
package cva6_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_BUBBLE = 2'd2,
    ST_DONE   = 2'd3
  } feeder_state_e;

  localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
  localparam logic [6:0]  OPC_STORE = 7'b0100011;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  function automatic logic is_memop(input logic [31:0] instr);
    return (instr[6:0] == OPC_LOAD) || (instr[6:0] == OPC_STORE);
  endfunction

endpackage

// File: rtl/cva6_feeder_prog_mem.sv
// Program store: one write port, asynchronous read, every slot resets to NOP.
module cva6_feeder_prog_mem
  import cva6_feeder_pkg::*;
#(
  parameter int PROG_DEPTH = 4,
  parameter int AW         = $clog2(PROG_DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [PROG_DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < PROG_DEPTH; i++) mem[i] <= INSTR_NOP;
    end else if (we_i && (int'(waddr_i) < PROG_DEPTH)) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/cva6_instr_feeder.sv
// Issues a loadable program over a valid/ready handshake, with a one-cycle bubble after each load/store.
module cva6_instr_feeder
  import cva6_feeder_pkg::*;
#(
  parameter int PROG_DEPTH = 4,
  parameter int PC_W       = $clog2(PROG_DEPTH) + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic                          prog_we_i,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_waddr_i,
  input  logic [31:0]                   prog_wdata_i,
  output logic [31:0]                   instr_o,
  output logic                          instr_valid_o,
  input  logic                          instr_ready_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [PC_W-1:0]               issued_cnt_o,
  output logic [PC_W-1:0]               memop_cnt_o
);

  localparam int AW = $clog2(PROG_DEPTH);

  feeder_state_e   state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] issued_cnt;
  logic [PC_W-1:0] memop_cnt;
  logic            valid_q;
  logic            busy_q;
  logic            done_q;
  logic [31:0]     cur_instr;
  logic            idle_or_done;
  logic            cur_memop;
  logic            last_slot;

  assign idle_or_done = (state == ST_IDLE) || (state == ST_DONE);
  assign cur_memop    = is_memop(cur_instr);
  assign last_slot    = (pc == PC_W'(PROG_DEPTH - 1));

  cva6_feeder_prog_mem #(
    .PROG_DEPTH (PROG_DEPTH),
    .AW         (AW)
  ) u_prog_mem (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (prog_we_i && idle_or_done),
    .waddr_i (prog_waddr_i),
    .wdata_i (prog_wdata_i),
    .raddr_i (pc[AW-1:0]),
    .rdata_o (cur_instr)
  );

  // pc stops at the last slot so it never indexes past the program.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      pc         <= '0;
      issued_cnt <= '0;
      memop_cnt  <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state      <= ST_ISSUE;
            pc         <= '0;
            issued_cnt <= '0;
            memop_cnt  <= '0;
            valid_q    <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (instr_ready_i) begin
            issued_cnt <= issued_cnt + PC_W'(1);
            if (cur_memop) memop_cnt <= memop_cnt + PC_W'(1);
            if (last_slot) begin
              state   <= ST_DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              pc <= pc + PC_W'(1);
              if (cur_memop) begin
                state   <= ST_BUBBLE;
                valid_q <= 1'b0;
              end
            end
          end
        end
        ST_BUBBLE: begin
          state   <= ST_ISSUE;
          valid_q <= 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign instr_o       = valid_q ? cur_instr : 32'h0;
  assign instr_valid_o = valid_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign issued_cnt_o  = issued_cnt;
  assign memop_cnt_o   = memop_cnt;

endmodule
